// File: rtl/dt_tick_sequencer.sv
// dt_tick_sequencer: credit-based theta issue to the arithmetic chain with a scaled dt tick FIFO
module dt_tick_sequencer #(
  parameter int unsigned THETA_W    = 12,
  parameter int unsigned COLUMNS    = 360,
  parameter int unsigned FRAMES     = 5,
  parameter int unsigned PIPE_W     = 39,
  parameter int unsigned FRAC_SHIFT = 20,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned DEPTH      = 8
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  input  logic               mode_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               req_valid_i,
  input  logic [THETA_W-1:0] req_theta_i,
  output logic               req_ready_o,
  output logic               pipe_valid_o,
  output logic [THETA_W-1:0] pipe_theta_o,
  input  logic               pipe_valid_i,
  input  logic [PIPE_W-1:0]  pipe_data_i,
  output logic               dt_valid_o,
  input  logic               dt_ready_i,
  output logic [OUT_W-1:0]   dt_o,
  output logic               dt_last_o,
  output logic               frame_o,
  output logic               busy_o,
  output logic               sat_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned HW = $clog2(FRAMES + 1);
  localparam int unsigned CW = AW + 2;
  localparam logic [THETA_W-1:0] TH_MAX = THETA_W'(COLUMNS - 1);
  localparam logic [HW-1:0] HS_MAX = HW'(FRAMES - 1);

  typedef enum logic [1:0] {IDLE, EXT, SWEEP, DRAIN} state_t;

  state_t state_q, state_d;
  logic [AW:0] inflight_q, inflight_d, count_q, count_d;
  logic [AW-1:0] wr_q, rd_q, tw_q, tr_q;
  logic [DEPTH-1:0] tag_q;
  logic [OUT_W:0] mem_q [DEPTH];
  logic stg_v_q, stg_last_q;
  logic [OUT_W-1:0] stg_dt_q;
  logic [THETA_W-1:0] th_q, th_d, pipe_theta_q;
  logic dir_q, dir_d, frame_q, frame_d, pipe_valid_q, sat_q;
  logic [HW-1:0] hs_q, hs_d;
  logic [PIPE_W-1:0] s;
  logic credit_ok, start_go, ext_issue, sw_issue, issue, at_end, ret, sat_hit, empty, push, pop;

  // The result stage counts against credit too, so a full FIFO can never see a push without a pop
  assign credit_ok = CW'(inflight_q) + CW'(count_q) + CW'(stg_v_q) < CW'(DEPTH);
  assign start_go  = (state_q == IDLE) & start_i;
  assign req_ready_o = (state_q == EXT) & credit_ok & !stop_i;
  assign ext_issue = req_ready_o & req_valid_i;
  assign sw_issue  = (state_q == SWEEP) & credit_ok & !stop_i;
  assign issue     = ext_issue | sw_issue;
  assign at_end    = dir_q ? th_q == '0 : th_q == TH_MAX;
  assign ret       = pipe_valid_i & (inflight_q != '0);
  assign s         = pipe_data_i >> FRAC_SHIFT;
  assign sat_hit   = (s >> OUT_W) != '0;
  assign empty     = count_q == '0;
  assign push      = stg_v_q;
  assign pop       = !empty & dt_ready_i;
  assign inflight_d = inflight_q + (AW+1)'(issue) - (AW+1)'(ret);
  assign count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);

  assign pipe_valid_o = pipe_valid_q;
  assign pipe_theta_o = pipe_theta_q;
  assign frame_o      = frame_q;
  assign sat_o        = sat_q;
  assign dt_valid_o   = !empty;
  assign dt_o         = empty ? '0 : mem_q[rd_q][OUT_W-1:0];
  assign dt_last_o    = !empty & mem_q[rd_q][OUT_W];
  assign busy_o       = (state_q != IDLE) | (inflight_q != '0) | stg_v_q | !empty;

  // Mode FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (start_i) state_d = mode_i ? SWEEP : EXT;
      EXT, SWEEP: if (stop_i) state_d = DRAIN;
      DRAIN:      if (inflight_q == '0 && !stg_v_q && empty) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Mirrored sweep: endpoint issued twice at each turn, every turn closes one half-sweep
  always_comb begin
    th_d = th_q;
    dir_d = dir_q;
    hs_d = hs_q;
    frame_d = 1'b0;
    if (start_go) begin
      th_d = '0;
      dir_d = 1'b0;
      hs_d = '0;
    end else if (sw_issue && at_end) begin
      dir_d = !dir_q;
      frame_d = hs_q == HS_MAX;
      hs_d = frame_d ? '0 : hs_q + HW'(1);
    end else if (sw_issue) begin
      th_d = dir_q ? th_q - THETA_W'(1) : th_q + THETA_W'(1);
    end
  end

  // FSM state, credit counters and sweep position
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= IDLE;
      inflight_q <= '0;
      count_q <= '0;
      th_q <= '0;
      dir_q <= 1'b0;
      hs_q <= '0;
    end else begin
      state_q <= state_d;
      inflight_q <= inflight_d;
      count_q <= count_d;
      th_q <= th_d;
      dir_q <= dir_d;
      hs_q <= hs_d;
    end
  end

  // Registered issue towards the chain, with the last flag queued until the result returns
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      pipe_valid_q <= 1'b0;
      pipe_theta_q <= '0;
      frame_q <= 1'b0;
      tag_q <= '0;
      tw_q <= '0;
    end else begin
      pipe_valid_q <= issue;
      frame_q <= frame_d;
      if (issue) begin
        pipe_theta_q <= ext_issue ? req_theta_i : th_q;
        tag_q[tw_q] <= sw_issue & at_end;
        tw_q <= tw_q + AW'(1);
      end
    end
  end

  // Scale/saturate stage on return, sticky saturation flag and FIFO pointers
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      stg_v_q <= 1'b0;
      stg_dt_q <= '0;
      stg_last_q <= 1'b0;
      tr_q <= '0;
      sat_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      stg_v_q <= ret;
      if (ret) begin
        stg_dt_q <= sat_hit ? '1 : s[OUT_W-1:0];
        stg_last_q <= tag_q[tr_q];
        tr_q <= tr_q + AW'(1);
      end
      sat_q <= start_go ? 1'b0 : sat_q | (ret & sat_hit);
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
    end
  end

  // FIFO storage; contents are masked by the empty flag so no reset is needed
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= {stg_last_q, stg_dt_q};
  end
endmodule

// File: tb/tb_dt_tick_sequencer.sv
// tb_dt_tick_sequencer: directed and randomized checks against a behavioural sweep/chain model
module tb_dt_tick_sequencer;
  localparam int TW = 12, C = 4, F = 2, PW = 39, FS = 20, OW = 16, D = 8;

  logic clk = 0, nrst = 0, mode = 0, start = 0, stop = 0, req_valid = 0;
  logic pipe_vi = 0, dt_ready = 0;
  logic [TW-1:0] req_theta = 0;
  logic [PW-1:0] pipe_data = 0;
  logic req_ready, pipe_vo, dt_valid, dt_last, frame, busy, sat;
  logic [TW-1:0] pipe_theta;
  logic [OW-1:0] dt;

  dt_tick_sequencer #(.THETA_W(TW), .COLUMNS(C), .FRAMES(F), .PIPE_W(PW), .FRAC_SHIFT(FS),
                      .OUT_W(OW), .DEPTH(D)) dut (
    .clk_i(clk), .nrst_i(nrst), .mode_i(mode), .start_i(start), .stop_i(stop),
    .req_valid_i(req_valid), .req_theta_i(req_theta), .req_ready_o(req_ready),
    .pipe_valid_o(pipe_vo), .pipe_theta_o(pipe_theta), .pipe_valid_i(pipe_vi),
    .pipe_data_i(pipe_data), .dt_valid_o(dt_valid), .dt_ready_i(dt_ready), .dt_o(dt),
    .dt_last_o(dt_last), .frame_o(frame), .busy_o(busy), .sat_o(sat));

  always #5 clk = ~clk;

  typedef struct { int due; logic [PW-1:0] raw; } ret_t;
  typedef struct { logic [OW-1:0] dt; logic last; } tick_t;

  ret_t pend[$];
  tick_t expq[$];
  logic [PW-1:0] raw_q[$];
  logic [TW-1:0] ext_q[$];
  int checks = 0, fails = 0;
  int cyc = 0, lat_lo = 2, lat_hi = 2, last_due = 0, sw_k = 0, issued = 0, popped = 0;
  int stray = 0, frames_seen = 0, base;
  logic sweep = 0, allow = 1, hold = 0, hold_last = 0;
  logic [OW-1:0] hold_dt = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] scale(logic [PW-1:0] raw);
    longint unsigned v = 64'(raw) / (64'(1) << FS);
    return v > 65535 ? 16'hFFFF : v[15:0];
  endfunction

  function automatic logic [PW-1:0] rand_raw();
    logic [63:0] v = {$urandom, $urandom};
    return ($urandom_range(0, 3) == 0) ? v[PW-1:0] : {3'b0, v[35:0]};
  endfunction

  task automatic observe();
    tick_t t;
    ret_t r;
    int p, l;
    logic exp_frame;
    exp_frame = 0;
    if (pipe_vo) begin
      chk("issue_allowed", allow, 1);
      issued++;
      if (sweep) begin
        p = sw_k % (2 * C);
        chk("sweep_theta", pipe_theta, p < C ? p : 2 * C - 1 - p);
        t.last = (p == C - 1) || (p == 2 * C - 1);
        exp_frame = ((sw_k + 1) % (C * F)) == 0;
        sw_k++;
      end else begin
        t.last = 0;
        chk("ext_issue_expected", ext_q.size() != 0, 1);
        if (ext_q.size() != 0) chk("ext_theta", pipe_theta, ext_q.pop_front());
      end
      r.raw = raw_q.size() != 0 ? raw_q.pop_front() : rand_raw();
      l = $urandom_range(lat_lo, lat_hi);
      r.due = (cyc + l > last_due + 1) ? cyc + l : last_due + 1;
      last_due = r.due;
      pend.push_back(r);
      t.dt = scale(r.raw);
      expq.push_back(t);
    end
    chk("frame", frame, exp_frame);
    if (frame) frames_seen++;
    chk("credit_bound", (issued - popped) <= D, 1);
    if (hold) begin
      chk("hold_valid", dt_valid, 1);
      chk("hold_dt", dt, hold_dt);
      chk("hold_last", dt_last, hold_last);
    end
    if (dt_valid && dt_ready) begin
      popped++;
      chk("tick_expected", expq.size() != 0, 1);
      if (expq.size() != 0) begin
        t = expq.pop_front();
        chk("dt", dt, t.dt);
        chk("dt_last", dt_last, t.last);
      end
    end
    hold = dt_valid && !dt_ready;
    hold_dt = dt;
    hold_last = dt_last;
    pipe_vi = 0;
    if (stray > 0) begin
      pipe_vi = 1;
      pipe_data = rand_raw();
      stray--;
    end else if (pend.size() != 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      pipe_vi = 1;
      pipe_data = r.raw;
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic do_start(logic m);
    mode = m;
    start = 1;
    step();
    start = 0;
    sweep = m;
    sw_k = 0;
    frames_seen = 0;
    allow = 1;
  endtask

  task automatic do_stop();
    stop = 1;
    step();
    stop = 0;
    allow = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    dt_ready = 1;
    while (busy && n < 1000) begin
      step();
      n++;
    end
    chk("idle_reached", busy, 0);
    chk("all_ticks_out", expq.size(), 0);
  endtask

  task automatic ext_req(logic [TW-1:0] th);
    int n = 0;
    req_valid = 1;
    req_theta = th;
    while (!req_ready && n < 200) begin
      step();
      n++;
    end
    chk("req_ready", req_ready, 1);
    if (req_ready) begin
      ext_q.push_back(th);
      step();
      chk("ext_issue_latency", pipe_vo, 1);
    end
    req_valid = 0;
  endtask

  initial begin
    #12;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_pipe_valid", pipe_vo, 0);
    chk("rst_pipe_theta", pipe_theta, 0);
    chk("rst_dt_valid", dt_valid, 0);
    chk("rst_dt", dt, 0);
    chk("rst_dt_last", dt_last, 0);
    chk("rst_frame", frame, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", sat, 0);
    @(posedge clk);
    #1;
    nrst = 1;
    step();
    // directed external requests
    dt_ready = 1;
    do_start(0);
    raw_q.push_back(39'h00_0050_0000);
    raw_q.push_back(39'h00_0060_0000);
    raw_q.push_back(39'h00_0070_0000);
    ext_req(5);
    ext_req(6);
    ext_req(7);
    do_stop();
    wait_idle();
    chk("ext_tick_count", popped, 3);
    // random external requests with random backpressure and latency
    lat_lo = 1;
    lat_hi = 6;
    do_start(0);
    for (int i = 0; i < 40; i++) begin
      dt_ready = $urandom_range(0, 3) != 0;
      ext_req(TW'($urandom));
      run($urandom_range(0, 2));
    end
    do_stop();
    wait_idle();
    // sweep with fixed latency
    lat_lo = 10;
    lat_hi = 10;
    dt_ready = 1;
    do_start(1);
    run(60);
    do_stop();
    wait_idle();
    chk("sweep_progress", sw_k >= 2 * C * F, 1);
    chk("frame_count", frames_seen, sw_k / (C * F));
    // sweep against a stalled consumer, then release
    lat_lo = 1;
    lat_hi = 4;
    dt_ready = 0;
    base = issued;
    do_start(1);
    run(40);
    chk("bp_issue_count", issued - base, D);
    chk("bp_stall", pipe_vo, 0);
    for (int i = 0; i < 100; i++) begin
      dt_ready = $urandom_range(0, 1);
      step();
    end
    do_stop();
    wait_idle();
    chk("no_loss", popped, issued);
    // saturation, sticky until the next start
    do_start(0);
    chk("sat_clear_on_start", sat, 0);
    raw_q.push_back(39'h7F_FFFF_FFFF);
    ext_req(9);
    do_stop();
    wait_idle();
    chk("sat_set", sat, 1);
    run(5);
    chk("sat_held", sat, 1);
    do_start(0);
    chk("sat_cleared", sat, 0);
    // stop with three in flight; a start pulse outside IDLE is ignored
    lat_lo = 10;
    lat_hi = 10;
    base = popped;
    ext_req(1);
    ext_req(2);
    ext_req(3);
    mode = 1;
    start = 1;
    step();
    start = 0;
    mode = 0;
    do_stop();
    chk("stop_busy", busy, 1);
    wait_idle();
    chk("stop_ticks", popped - base, 3);
    chk("idle_req_ready", req_ready, 0);
    // reset mid-flight, then stray returns
    lat_lo = 20;
    lat_hi = 20;
    do_start(0);
    for (int i = 0; i < 4; i++) ext_req(TW'(i + 20));
    run(2);
    nrst = 0;
    hold = 0;
    pend.delete();
    expq.delete();
    ext_q.delete();
    issued = 0;
    popped = 0;
    allow = 0;
    run(2);
    chk("midrst_busy", busy, 0);
    chk("midrst_pipe_valid", pipe_vo, 0);
    nrst = 1;
    step();
    stray = 4;
    run(10);
    chk("stray_dt_valid", dt_valid, 0);
    chk("stray_busy", busy, 0);
    chk("stray_popped", popped, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/dt_tick_sequencer.md
Name: dt_tick_sequencer

Overview:
- Parametrised successor to the per-column dt-tick path: drives theta iterations into the external trig/arctan/mul/div arithmetic chain and buffers the returned dt ticks.
- Supports an external request mode and an autonomous bidirectional sweep mode (columns ascending, then mirrored descending).
- Uses credit-based issue so a result is never dropped, even under output backpressure.
- Presents scaled and saturated dt ticks on a valid/ready stream with line/frame markers, for consumption by the mirror timing logic.

Parameters:
- THETA_W, 12, width of a theta iteration index.
- COLUMNS, 360, columns per half-sweep (auto mode wraps at COLUMNS-1).
- FRAMES, 5, half-sweeps per frame group (frame_o pulse period).
- PIPE_W, 39, width of the raw result returned by the arithmetic chain.
- FRAC_SHIFT, 20, right shift applied to the raw result.
- OUT_W, 16, output dt tick width.
- DEPTH, 8, result FIFO depth (power of 2, >=2).

Ports:
- clk_i  in  1  clock.
- nrst_i  in  1  reset, asynchronous, active-low.
- mode_i  in  1  0 = external request, 1 = auto sweep; sampled only in IDLE.
- start_i  in  1  leave IDLE (pulse).
- stop_i  in  1  stop issuing; drain, then return to IDLE.
- req_valid_i  in  1  external theta request valid.
- req_theta_i  in  THETA_W  external theta index.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- pipe_valid_o  out  1  issue pulse to arithmetic chain.
- pipe_theta_o  out  THETA_W  issued theta.
- pipe_valid_i  in  1  result return pulse, in issue order.
- pipe_data_i  in  PIPE_W  raw unsigned result.
- dt_valid_o  out  1  output tick valid.
- dt_ready_i  in  1  downstream ready.
- dt_o  out  OUT_W  scaled tick.
- dt_last_o  out  1  tick belongs to the final column of a half-sweep.
- frame_o  out  1  one-cycle pulse when FRAMES half-sweeps have been issued.
- busy_o  out  1  not IDLE, or credits outstanding.
- sat_o  out  1  sticky; set when any result saturated; cleared on start_i.

Behaviour:
- Reset: state IDLE; all counters 0; direction up; FIFO empty. Reset values of outputs:
  - req_ready_o = 0, pipe_valid_o = 0, pipe_theta_o = 0.
  - dt_valid_o = 0, dt_o = 0, dt_last_o = 0.
  - frame_o = 0, busy_o = 0, sat_o = 0.
- States:
  - IDLE: start_i goes to EXT or SWEEP according to mode_i.
  - EXT: req_ready_o = credit_ok. Each accepted request issues next cycle (pipe_valid_o registered, 1-cycle latency).
  - SWEEP: issues one theta per cycle while credit_ok.
    - Theta counts 0..COLUMNS-1, then COLUMNS-1..0; the endpoint is repeated at each turn (mirror behaviour).
    - Each turn counts one half-sweep. frame_o pulses in the cycle of the issue that completes half-sweep FRAMES; the half-sweep counter then wraps to 0.
  - DRAIN: entered from EXT/SWEEP on stop_i. No new issues. Goes to IDLE when in-flight = 0 and FIFO empty.
  - start_i outside IDLE is ignored.
- Credits:
  - credit_ok = (inflight + fifo_count) < DEPTH.
  - inflight increments on issue and decrements on pipe_valid_i; simultaneous increment and decrement leaves it unchanged.
  - pipe_valid_i with inflight = 0 is a protocol error: ignore the data, no FIFO write.
- Result processing, registered before the FIFO write (1 cycle):
  - s = pipe_data_i >> FRAC_SHIFT.
  - If s > 2^OUT_W - 1, write all-ones and set sat_o; otherwise write s[OUT_W-1:0].
  - The last flag is carried with each issue through a DEPTH-entry tag queue, matched on return. In EXT mode last is always 0.
- FIFO:
  - First-word fall-through: dt_valid_o = !empty.
  - Pop when dt_valid_o & dt_ready_i.
  - Simultaneous push and pop on a full FIFO is legal. The credit scheme prevents a push into a full FIFO without a pop.
- Output stability: dt_o and dt_last_o hold while dt_valid_o & !dt_ready_i.
- busy_o = (state != IDLE) | inflight != 0 | !empty.
- nrst_i mid-operation: immediate clear of all state. In-flight results returned after reset are discarded because inflight = 0.

Test Plan:
- EXT mode, 3 requests theta = 5, 6, 7, chain returns 0x0000500000, 0x0000600000, 0x0000700000 -> dt_o = 0x0005, 0x0006, 0x0007 in order; dt_last_o = 0.
- SWEEP with COLUMNS = 4, FRAMES = 2, dt_ready_i = 1, chain latency 10 -> pipe_theta_o sequence 0,1,2,3,3,2,1,0,0,...; dt_last_o set on the 4th and 8th ticks; frame_o pulses once on the 8th issue.
- dt_ready_i = 0 with DEPTH = 8 in SWEEP -> exactly 8 issues, then pipe_valid_o held low. Releasing dt_ready_i resumes issue; no tick lost or duplicated.
- Raw result 0x7F_FFFF_FFFF (exceeds 16 bits after >>20) -> dt_o = 0xFFFF, sat_o = 1, held until the next start_i.
- stop_i with 3 in flight -> no further issues; 3 ticks delivered; busy_o falls after the last pop; state returns to IDLE.
- nrst_i asserted with 4 in flight, released, then 4 stray pipe_valid_i pulses -> FIFO stays empty, dt_valid_o = 0, busy_o = 0.
